// File: rtl/prio_irq_encoder.sv
// prio_irq_encoder: edge-captured, masked, registered priority encoder with valid/ready output (optional PRIO_IRQ_OVERFLOW_EN)
module prio_irq_encoder #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] idx,
  output logic [N-1:0] pending,
  output logic         overflow
);
  typedef enum logic {IDLE, PRESENT} state_t;
  state_t state, state_n;
  logic [N-1:0] req_d, rise, clr, c;
  logic [W-1:0] idx_n, hi;
  logic acc;
  assign rise = req & ~req_d;
  assign acc = (state == PRESENT) & ready;
  assign clr = acc ? (N'(1) << idx) : '0;
  assign c = pending & mask;
  assign valid = state == PRESENT;
  // highest set index of the candidate vector; line N-1 wins
  always_comb begin
    hi = '0;
    for (int i = 0; i < N; i++) if (c[i]) hi = W'(i);
  end
  // next state: latch the winner in IDLE, hold it in PRESENT until accepted
  always_comb begin
    state_n = state;
    idx_n = idx;
    if (state == IDLE) begin
      state_n = |c ? PRESENT : IDLE;
      idx_n = |c ? hi : idx;
    end else begin
      state_n = ready ? IDLE : PRESENT;
    end
  end
  // state, index, edge history and sticky pending bits (a new edge beats a same-cycle clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      req_d <= '0;
      pending <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      req_d <= req;
      pending <= (pending & ~clr) | rise;
    end
  end
`ifdef PRIO_IRQ_OVERFLOW_EN
  // sticky flag for an edge landing on a still-pending, not-being-accepted line
  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else if (|(rise & pending & ~clr)) overflow <= 1'b1;
  end
`else
  assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_prio_irq_encoder.sv
// tb_prio_irq_encoder: directed self-checking bench for prio_irq_encoder (N=8)
module tb_prio_irq_encoder;
  logic clk = 0, rst = 1, ready = 0;
  logic [7:0] req = 8'hFF, mask = 8'hFF, pending;
  logic [2:0] idx;
  logic valid, overflow;
  int total = 0, passed = 0;
`ifdef PRIO_IRQ_OVERFLOW_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif
  prio_irq_encoder #(.N(8)) dut (.clk(clk), .rst(rst), .req(req), .mask(mask), .ready(ready),
    .valid(valid), .idx(idx), .pending(pending), .overflow(overflow));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    step(2);
    check("rst_valid", valid, 0);
    check("rst_idx", idx, 0);
    check("rst_pending", pending, 0);
    check("rst_ovf", overflow, 0);
    rst = 0;
    step();
    check("rel_pending", pending, 8'hFF);
    check("rel_valid", valid, 0);
    step();
    check("rel_valid2", valid, 1);
    check("rel_idx", idx, 7);
    req = 0;
    ready = 1;
    step(16);
    check("drain_pending", pending, 0);
    check("drain_valid", valid, 0);
    req = 8'b0101_0010;
    step();
    req = 0;
    check("prio_pending", pending, 8'h52);
    step();
    check("prio_v6", valid, 1);
    check("prio_i6", idx, 6);
    step();
    check("prio_bub1", valid, 0);
    check("prio_pend1", pending, 8'h12);
    step();
    check("prio_i4", idx, 4);
    check("prio_v4", valid, 1);
    step();
    check("prio_bub2", valid, 0);
    step();
    check("prio_i1", idx, 1);
    check("prio_v1", valid, 1);
    step();
    check("prio_end_v", valid, 0);
    check("prio_end_p", pending, 0);
    ready = 0;
    req = 8'h04;
    step();
    req = 0;
    step();
    check("hold_i2", idx, 2);
    req = 8'h80;
    step();
    req = 0;
    check("hold_pend", pending, 8'h84);
    check("hold_i", idx, 2);
    step();
    check("hold_i_b", idx, 2);
    check("hold_v_b", valid, 1);
    ready = 1;
    step();
    check("hold_bub", valid, 0);
    check("hold_pend2", pending, 8'h80);
    step();
    check("hold_i7", idx, 7);
    check("hold_v7", valid, 1);
    step();
    check("hold_end", valid, 0);
    mask = 8'b1101_1111;
    req = 8'h28;
    step();
    req = 0;
    step();
    check("mask_i3", idx, 3);
    check("mask_v3", valid, 1);
    step();
    check("mask_pend", pending, 8'h20);
    step();
    check("mask_idle", valid, 0);
    check("mask_idx_hold", idx, 3);
    check("mask_pend2", pending, 8'h20);
    mask = 8'hFF;
    step();
    check("mask_i5", idx, 5);
    check("mask_v5", valid, 1);
    step();
    check("mask_end", pending, 0);
    ready = 0;
    req = 8'h10;
    step();
    req = 0;
    step();
    check("sw_i4", idx, 4);
    ready = 1;
    req = 8'h10;
    step();
    ready = 0;
    req = 0;
    check("sw_pend", pending, 8'h10);
    check("sw_bub", valid, 0);
    step();
    check("sw_i4b", idx, 4);
    check("sw_v4b", valid, 1);
    check("sw_ovf", overflow, 0);
    ready = 1;
    step();
    ready = 0;
    check("sw_end", pending, 0);
    req = 8'h01;
    step();
    req = 0;
    step();
    check("ovf_i0", idx, 0);
    check("ovf_v0", valid, 1);
    req = 8'h01;
    step();
    req = 0;
    step();
    check("ovf_set", overflow, OVF);
    req = 8'h01;
    step();
    req = 0;
    ready = 1;
    step();
    ready = 0;
    step();
    check("ovf_sticky", overflow, OVF);
    check("ovf_pend", pending, 0);
    rst = 1;
    step();
    rst = 0;
    check("ovf_rst", overflow, 0);
    check("ovf_rst_v", valid, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/prio_irq_encoder.md
# prio_irq_encoder

Parametrised, registered priority encoder for N event-request lines. Captures rising edges into sticky pending bits, applies a per-line mask, presents the highest-numbered unmasked pending line as a binary index over a valid/ready handshake, and clears that line's pending bit on acceptance. Generalises the 4-to-2 combinational priority encoder for use as an interrupt/event front end feeding a sequential consumer.

## Interface
- N, default 8: number of request lines, 2..64.
- W, default $clog2(N): index width, derived and not overridden.

- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N  request lines; a rising edge (0→1 between samples) is one event.
- mask  in  N  1 = line enabled for presentation; 0 = held pending, not presented.
- ready  in  1  consumer accepts the presented index this cycle.
- valid  out  1  idx holds a live event.
- idx  out  W  index of the highest-priority line presented; line N-1 is highest.
- pending  out  N  current pending bits, registered.
- overflow  out  1  sticky event-loss flag (only with PRIO_IRQ_OVERFLOW_EN; tied 0 otherwise).

## Operation
- Edge detect: req_d registers req every cycle; edge[i] = req[i] & ~req_d[i].
- pending[i] set on edge[i]; cleared only by acceptance of line i or rst.
- Set and clear of the same bit in the same cycle: set wins, pending[i] stays 1 (new event preserved).
- Candidate vector c = pending & mask; priority = highest set index in c.
- FSM, two states:
  - IDLE: valid=0. If c != 0, register idx = highest set index of c, go PRESENT.
  - PRESENT: valid=1, idx frozen. On ready=1: clear pending[idx] (subject to set-wins rule), go IDLE.
- idx and valid never change while in PRESENT and ready=0, even if a higher line becomes pending or mask[idx] drops to 0; the presented event must be taken.
- ready while valid=0 is ignored.
- c == 0 in IDLE: stay IDLE, idx holds its previous value.

## Timing
- Reset values: valid=0, idx=0, pending=0, req_d=0, overflow=0, state IDLE.
- req_d resets to 0: a req line held high through reset release produces one event on the first cycle after reset.
- Latency: req rises before edge k → pending[i]=1 after edge k → valid=1, idx=i after edge k+1 (2 cycles).
- Accept at edge a (valid & ready) → valid=0 after edge a; next candidate presented after edge a+1. Throughput: one event per 2 cycles; one bubble cycle per acceptance is required.
- Mask changes take effect at the next IDLE evaluation; no effect on an event already in PRESENT.
- rst asserted mid-handshake: all state returns to reset values at that edge, pending events lost, no acceptance performed.

## Configuration
- PRIO_IRQ_OVERFLOW_EN defined: overflow sets when edge[i] occurs while pending[i]=1 and line i is not being accepted that cycle (a lost event). Sticky until rst. Registered; visible the cycle after the offending edge.
- Not defined: no overflow logic; overflow output driven constant 0; repeated edges on a pending line are silently merged.

## Test plan
- Reset: assert rst 2 cycles with req=8'hFF → valid=0, idx=0, pending=0; release rst, req held 8'hFF → pending=8'hFF 1 cycle later, valid=1 with idx=7 2 cycles later.
- Priority order: N=8, mask=8'hFF, pulse req bits 1, 4, 6 together, ready=1 constantly → idx sequence 6, 4, 1, each valid for 1 cycle separated by 1 bubble; pending ends 0.
- Hold: event on line 2 presented, ready=0; then pulse line 7 → idx stays 2, valid stays 1; assert ready → after bubble idx=7.
- Mask: pulse lines 5 and 3, mask=8'b1101_1111 → only idx=3 presented; pending[5] stays 1; set mask[5]=1 → idx=5 presented 1 cycle later.
- Set-wins collision: line 4 presented, new rising edge on req[4] in the accept cycle → pending[4] remains 1, idx=4 presented again after bubble.
- Overflow (macro on): line 0 pending, ready=0, two further rising edges on req[0] → overflow=1 and stays 1 after acceptance until rst; macro off → overflow=0 throughout.
